// File: rtl/candle_pkg.sv
// Shared types and defaults for the candle lifecycle sequencer.
// Saturating 8-bit helpers keep the brightness level from ever wrapping.
package candle_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IGNITE = 3'd1,
        ST_BURN   = 3'd2,
        ST_GUST   = 3'd3,
        ST_SNUFF  = 3'd4
    } state_e;

    localparam int unsigned DEF_RAMP_STEP  = 4;
    localparam int unsigned DEF_GUST_LEN   = 64;
    localparam logic [3:0]  DEF_GUST_CODE  = 4'hF;
    localparam int unsigned DEF_GUST_SHIFT = 1;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// rising-edge detector producing a one-clock pulse.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    // sync_q[1] is the synchronized level; sync_q[2] is its one-clock history.
    assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/candle_sequencer.sv
// Candle lifecycle controller: ramps up on light, passes flicker through while
// burning, dims during random gusts, and ramps down on snuff.
module candle_sequencer
    import candle_pkg::*;
#(
    parameter int unsigned RAMP_STEP  = DEF_RAMP_STEP,
    parameter int unsigned GUST_LEN   = DEF_GUST_LEN,
    parameter logic [3:0]  GUST_CODE  = DEF_GUST_CODE,
    parameter int unsigned GUST_SHIFT = DEF_GUST_SHIFT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       light,
    input  logic       snuff,
    input  logic [7:0] flkr,
    input  logic [3:0] lfsr,
    output logic [7:0] value,
    output logic       pwm_on,
    output logic [2:0] state
);

    localparam logic [7:0] STEP        = 8'(RAMP_STEP);
    localparam logic [7:0] GUST_RELOAD = 8'(GUST_LEN - 1);

    logic       light_ev;
    logic       snuff_ev;
    state_e     state_q;
    state_e     state_d;
    logic [7:0] level_q;
    logic [7:0] level_d;
    logic [7:0] gust_tmr_q;
    logic [7:0] gust_tmr_d;
    logic [7:0] gust_val;
    logic       ramp_done;

    edge_sync u_light_sync (
        .clk   (clk),
        .rst_n (rst),
        .din   (light),
        .pulse (light_ev)
    );

    edge_sync u_snuff_sync (
        .clk   (clk),
        .rst_n (rst),
        .din   (snuff),
        .pulse (snuff_ev)
    );

    assign gust_val  = flkr >> GUST_SHIFT;
    // 9-bit compare so level + step cannot wrap past the target.
    assign ramp_done = ({1'b0, level_q} + {1'b0, STEP}) >= {1'b0, flkr};

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        gust_tmr_d = gust_tmr_q;

        case (state_q)
            ST_OFF: begin
                level_d = '0;
                if (light_ev && !snuff_ev) state_d = ST_IGNITE;
            end

            ST_IGNITE: begin
                if (snuff_ev) begin
                    state_d = ST_SNUFF;
                end else if (tick) begin
                    if (ramp_done) begin
                        level_d = flkr;
                        state_d = ST_BURN;
                    end else begin
                        level_d = sat_add8(level_q, STEP);
                    end
                end
            end

            ST_BURN: begin
                if (snuff_ev) begin
                    level_d = flkr;
                    state_d = ST_SNUFF;
                end else if (tick && (lfsr == GUST_CODE)) begin
                    gust_tmr_d = GUST_RELOAD;
                    state_d    = ST_GUST;
                end
            end

            ST_GUST: begin
                if (snuff_ev) begin
                    level_d = gust_val;
                    state_d = ST_SNUFF;
                end else if (tick) begin
                    if (gust_tmr_q == '0) state_d = ST_BURN;
                    else                  gust_tmr_d = gust_tmr_q - 8'd1;
                end
            end

            ST_SNUFF: begin
                // Re-light resumes the ramp from wherever the fade has reached.
                if (light_ev && !snuff_ev) begin
                    state_d = ST_IGNITE;
                end else if (tick && !light_ev && !snuff_ev) begin
                    if (level_q <= STEP) begin
                        level_d = '0;
                        state_d = ST_OFF;
                    end else begin
                        level_d = sat_sub8(level_q, STEP);
                    end
                end
            end

            default: begin
                state_d    = ST_OFF;
                level_d    = '0;
                gust_tmr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            level_q    <= '0;
            gust_tmr_q <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            gust_tmr_q <= gust_tmr_d;
        end
    end

    // Output stage is registered from the current state, one clock behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value  <= '0;
            pwm_on <= 1'b0;
        end else begin
            case (state_q)
                ST_IGNITE, ST_SNUFF: value <= level_q;
                ST_BURN:             value <= flkr;
                ST_GUST:             value <= gust_val;
                default:             value <= '0;
            endcase
            pwm_on <= state_q inside {ST_IGNITE, ST_BURN, ST_GUST, ST_SNUFF};
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_candle_sequencer.sv
// Scenario bench for candle_sequencer: expected brightness values are queued as
// ticks are driven and popped when the registered output reflects them.
module tb_candle_sequencer;

    localparam int unsigned RAMP  = 4;
    localparam int unsigned GLEN  = 64;
    localparam logic [3:0]  GCODE = 4'hF;
    localparam int unsigned GSH   = 1;

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_IGNITE = 3'd1;
    localparam logic [2:0] S_BURN   = 3'd2;
    localparam logic [2:0] S_GUST   = 3'd3;
    localparam logic [2:0] S_SNUFF  = 3'd4;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       light;
    logic       snuff;
    logic [7:0] flkr;
    logic [3:0] lfsr;
    logic [7:0] value;
    logic       pwm_on;
    logic [2:0] state;

    int         n_checks;
    int         n_errors;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    candle_sequencer #(
        .RAMP_STEP  (RAMP),
        .GUST_LEN   (GLEN),
        .GUST_CODE  (GCODE),
        .GUST_SHIFT (GSH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .light  (light),
        .snuff  (snuff),
        .flkr   (flkr),
        .lfsr   (lfsr),
        .value  (value),
        .pwm_on (pwm_on),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick_once();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Drives ticks until the DUT reaches target; a missed bound counts as a failure.
    task automatic run_until(input logic [2:0] target, input string name);
        int i;
        i = 0;
        while (state !== target && i < 200) begin
            tick_once();
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (state !== target) begin
            n_errors++;
            $display("FAIL %s: state=%0d expected %0d after %0d ticks", name, state, target, i);
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (value !== 8'd0 || pwm_on !== 1'b0 || state !== S_OFF) begin
            n_errors++;
            $display("FAIL reset_hold: value=%0d pwm_on=%0b state=%0d expected 0/0/0", value, pwm_on, state);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== S_OFF || value !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_release: state=%0d value=%0d expected 0/0", state, value);
        end
    endtask

    task automatic test_light();
        flkr  = 8'd200;
        lfsr  = 4'h0;
        light = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state !== S_OFF) begin
            n_errors++;
            $display("FAIL light_latency: state=%0d expected %0d", state, S_OFF);
        end
        @(negedge clk);
        n_checks++;
        if (state !== S_IGNITE) begin
            n_errors++;
            $display("FAIL light_ignite: state=%0d expected %0d", state, S_IGNITE);
        end
        light = 1'b0;
        exp_q.push_back(8'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (value !== e || pwm_on !== 1'b1) begin
            n_errors++;
            $display("FAIL ignite_start: value=%0d pwm_on=%0b expected %0d/1", value, pwm_on, e);
        end
        for (int k = 1; k <= 50; k++) begin
            exp_q.push_back((k < 50) ? 8'(RAMP * k) : 8'd200);
            tick_once();
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (value !== e) begin
                n_errors++;
                $display("FAIL ramp_up tick %0d: value=%0d expected %0d", k, value, e);
            end
            n_checks++;
            if (state !== ((k < 50) ? S_IGNITE : S_BURN)) begin
                n_errors++;
                $display("FAIL ramp_state tick %0d: state=%0d expected %0d", k, state,
                         (k < 50) ? S_IGNITE : S_BURN);
            end
        end
        n_checks++;
        if (pwm_on !== 1'b1) begin
            n_errors++;
            $display("FAIL burn_pwm: pwm_on=%0b expected 1", pwm_on);
        end
    endtask

    task automatic test_gust();
        flkr = 8'd120;
        @(negedge clk);
        n_checks++;
        if (value !== 8'd120) begin
            n_errors++;
            $display("FAIL burn_track: value=%0d expected 120", value);
        end
        flkr = 8'd200;
        @(negedge clk);
        lfsr = GCODE;
        exp_q.push_back(8'(200 >> GSH));
        tick_once();
        lfsr = 4'h0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (value !== e || state !== S_GUST) begin
            n_errors++;
            $display("FAIL gust_enter: value=%0d state=%0d expected %0d/%0d", value, state, e, S_GUST);
        end
        for (int i = 1; i <= int'(GLEN); i++) begin
            if (i == 32) lfsr = GCODE;
            exp_q.push_back((i < int'(GLEN)) ? 8'(200 >> GSH) : 8'd200);
            tick_once();
            lfsr = 4'h0;
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (value !== e) begin
                n_errors++;
                $display("FAIL gust tick %0d: value=%0d expected %0d", i, value, e);
            end
        end
        n_checks++;
        if (state !== S_BURN) begin
            n_errors++;
            $display("FAIL gust_exit: state=%0d expected %0d", state, S_BURN);
        end
    endtask

    task automatic test_snuff();
        snuff = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state !== S_BURN) begin
            n_errors++;
            $display("FAIL snuff_latency: state=%0d expected %0d", state, S_BURN);
        end
        @(negedge clk);
        n_checks++;
        if (state !== S_SNUFF) begin
            n_errors++;
            $display("FAIL snuff_enter: state=%0d expected %0d", state, S_SNUFF);
        end
        snuff = 1'b0;
        exp_q.push_back(8'd200);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (value !== e) begin
            n_errors++;
            $display("FAIL snuff_start: value=%0d expected %0d", value, e);
        end
        for (int k = 1; k <= 50; k++) begin
            exp_q.push_back((k < 50) ? 8'(200 - RAMP * k) : 8'd0);
            tick_once();
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (value !== e) begin
                n_errors++;
                $display("FAIL ramp_down tick %0d: value=%0d expected %0d", k, value, e);
            end
        end
        n_checks++;
        if (state !== S_OFF || pwm_on !== 1'b0) begin
            n_errors++;
            $display("FAIL snuff_off: state=%0d pwm_on=%0b expected 0/0", state, pwm_on);
        end
    endtask

    task automatic test_relight();
        flkr  = 8'd100;
        light = 1'b1;
        repeat (3) @(negedge clk);
        light = 1'b0;
        run_until(S_BURN, "relight_burn100");
        snuff = 1'b1;
        repeat (3) @(negedge clk);
        snuff = 1'b0;
        flkr  = 8'd200;
        exp_q.push_back(8'd100);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (value !== e || state !== S_SNUFF) begin
            n_errors++;
            $display("FAIL relight_fade: value=%0d state=%0d expected %0d/%0d", value, state, e, S_SNUFF);
        end
        light = 1'b1;
        repeat (3) @(negedge clk);
        light = 1'b0;
        n_checks++;
        if (state !== S_IGNITE) begin
            n_errors++;
            $display("FAIL relight_state: state=%0d expected %0d", state, S_IGNITE);
        end
        exp_q.push_back(8'd100);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (value !== e) begin
            n_errors++;
            $display("FAIL relight_hold: value=%0d expected %0d", value, e);
        end
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(8'(100 + RAMP * k));
            tick_once();
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (value !== e) begin
                n_errors++;
                $display("FAIL relight tick %0d: value=%0d expected %0d", k, value, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        run_until(S_BURN, "simul_burn");
        light = 1'b1;
        snuff = 1'b1;
        repeat (3) @(negedge clk);
        light = 1'b0;
        snuff = 1'b0;
        n_checks++;
        if (state !== S_SNUFF) begin
            n_errors++;
            $display("FAIL simul_burn_snuff: state=%0d expected %0d", state, S_SNUFF);
        end
        run_until(S_OFF, "simul_fade_off");
        light = 1'b1;
        snuff = 1'b1;
        repeat (4) @(negedge clk);
        light = 1'b0;
        snuff = 1'b0;
        n_checks++;
        if (state !== S_OFF || value !== 8'd0 || pwm_on !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_off: state=%0d value=%0d pwm_on=%0b expected 0/0/0", state, value, pwm_on);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        flkr  = 8'd200;
        light = 1'b1;
        repeat (3) @(negedge clk);
        light = 1'b0;
        run_until(S_BURN, "reset_burn");
        lfsr = GCODE;
        tick_once();
        lfsr = 4'h0;
        repeat (3) tick_once();
        n_checks++;
        if (state !== S_GUST || value !== 8'(200 >> GSH)) begin
            n_errors++;
            $display("FAIL reset_pre_gust: state=%0d value=%0d expected %0d/%0d", state, value, S_GUST, 200 >> GSH);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (value !== 8'd0 || pwm_on !== 1'b0 || state !== S_OFF) begin
            n_errors++;
            $display("FAIL async_reset: value=%0d pwm_on=%0b state=%0d expected 0/0/0", value, pwm_on, state);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick_once();
        @(negedge clk);
        n_checks++;
        if (state !== S_OFF || value !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_stays_off: state=%0d value=%0d expected 0/0", state, value);
        end
        // Zero target: the first tick of IGNITE lands straight in BURN.
        flkr  = 8'd0;
        light = 1'b1;
        repeat (3) @(negedge clk);
        light = 1'b0;
        exp_q.push_back(8'd0);
        tick_once();
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (state !== S_BURN || value !== e || pwm_on !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_target: state=%0d value=%0d pwm_on=%0b expected %0d/%0d/1",
                     state, value, pwm_on, S_BURN, e);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b0;
        tick  = 1'b0;
        light = 1'b0;
        snuff = 1'b0;
        flkr  = 8'd0;
        lfsr  = 4'h0;

        test_reset();
        test_light();
        test_gust();
        test_snuff();
        test_relight();
        test_simultaneous();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/candle_sequencer.md
# candle_sequencer

Lifecycle controller for the candle-flicker datapath: it sits between the flicker generator and the PWM stage and decides what brightness the PWM receives. It sequences the candle through lighting (ramp-up), steady burn (pass-through flicker), random wind gusts (dimmed), and snuffing (ramp-down). It also gates the PWM enable.

## Interface
- `RAMP_STEP`, default 4: brightness change per tick during ramp-up and ramp-down (1..255).
- `GUST_LEN`, default 64: gust duration in ticks (1..255).
- `GUST_CODE`, default 4'hF: LFSR value that triggers a gust.
- `GUST_SHIFT`, default 1: gust brightness is `flkr >> GUST_SHIFT` (0..7).

- `clk` in 1: single system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `tick` in 1: flicker-rate enable, one `clk` wide.
- `light` in 1: light request, asynchronous level (button); acts on its rising edge.
- `snuff` in 1: snuff request, asynchronous level (button); acts on its rising edge.
- `flkr` in 8: current flicker brightness.
- `lfsr` in 4: random bits from the LFSR.
- `value` out 8: brightness to the PWM.
- `pwm_on` out 1: PWM enable gate; 0 means output held low.
- `state` out 3: current state encoding (debug/IO).

## Operation
- **Input conditioning:** `light` and `snuff` each pass through a 2-flop synchronizer and then a rising-edge detector. This produces `light_ev` and `snuff_ev`, one-clock pulses.
- **States:** OFF=0, IGNITE=1, BURN=2, GUST=3, SNUFF=4. Codes 5–7 are illegal and go to OFF on the next clk.
- **Internal registers:** 8-bit `level`; 8-bit `gust_tmr`.
- **OFF:** `level`=0.
  - `light_ev` with no `snuff_ev` → IGNITE.
  - `light_ev` together with `snuff_ev` → stays OFF.
- **IGNITE:** on `tick`, if `level`+RAMP_STEP ≥ `flkr` (9-bit compare), load `level`=`flkr` and go to BURN. Otherwise `level` += RAMP_STEP.
- **BURN:** on `tick` with `lfsr`==GUST_CODE, load `gust_tmr`=GUST_LEN−1 and go to GUST.
- **GUST:** on `tick`, if `gust_tmr`==0 go to BURN, else decrement `gust_tmr`. A matching `lfsr` during GUST is ignored (no retrigger).
- **Snuff request:** `snuff_ev` in IGNITE, BURN or GUST → SNUFF, loading `level` with the brightness currently being displayed:
  - IGNITE: `level`.
  - BURN: `flkr`.
  - GUST: `flkr>>GUST_SHIFT`.
- **SNUFF:** on `tick`, if `level` ≤ RAMP_STEP, set `level`=0 and go to OFF. Otherwise `level` −= RAMP_STEP.
  - `light_ev` without `snuff_ev` → IGNITE, keeping the current `level` (re-light mid-fade).
- **Priority:** `snuff_ev` beats `light_ev`, and both beat `tick`-driven transitions in the same cycle. Edge events act on any clk; ramps and timers advance only on `tick`.
- **Value mapping** (registered from the current state):
  - OFF: 0.
  - IGNITE and SNUFF: `level`.
  - BURN: `flkr`.
  - GUST: `flkr>>GUST_SHIFT`.
- **`pwm_on`:** 1 in every state except OFF.
- **Arithmetic:** all add/subtract is saturating; `level` never wraps.

## Timing
- **Reset:** `rst` low immediately forces `state`=OFF, `level`=0, `gust_tmr`=0, `value`=0, `pwm_on`=0, all sync and edge flops 0. This holds mid-ramp and mid-gust.
- **Edge latency:** if `light` or `snuff` is high before clk edge k, the state changes at edge k+2.
- **Output latency:** `state` changes at edge n; `value` and `pwm_on` reflect the new state at edge n+1.
- **BURN/GUST tracking:** `value` follows `flkr` with one clk latency.
- **Held inputs:** a held `light` or `snuff` produces exactly one event. Pulses shorter than one clk period may be missed.
- **Ramp duration:** IGNITE from 0 to target T takes ceil(T/RAMP_STEP) ticks, with a minimum of 1 (T=0 goes to BURN on the first tick).
- **Gust duration:** exactly GUST_LEN ticks.

## Structure
- **Package `candle_pkg`:**
  - State enum (3-bit codes above).
  - Default constants for RAMP_STEP, GUST_LEN, GUST_CODE, GUST_SHIFT.
- **Sub-module `edge_sync`:** 2-flop synchronizer plus rising-edge pulse, with async active-low reset. Instantiated twice (light, snuff).
- **Top level:** state register, `level`, `gust_tmr` and the output register live in `candle_sequencer`.

## Test plan
- **Light ramp:** `flkr`=200, RAMP_STEP=4, pulse `light`.
  - → IGNITE 2 clks after the input rises; `value` steps 4, 8, … per tick.
  - BURN on the 50th tick; `value`=200 and `pwm_on`=1.
- **Gust:** in BURN with `flkr`=200, `lfsr`=4'hF on a tick.
  - → GUST, `value`=100 for exactly 64 ticks, then BURN with `value`=200.
  - `lfsr`=4'hF during GUST does not extend it.
- **Snuff:** from BURN (`flkr`=200), pulse `snuff`.
  - → SNUFF; `value` falls 196, 192, … per tick.
  - OFF after 50 ticks; `value`=0 and `pwm_on`=0.
- **Re-light mid-fade:** pulse `light` during SNUFF at `level`=100.
  - → IGNITE; `value` resumes from 100 upward (104, 108, …).
- **Simultaneous edges:** `light` and `snuff` rise together.
  - In BURN → SNUFF.
  - In OFF → stays OFF, `value`=0.
- **Async reset:** drop `rst` mid-GUST between clk edges.
  - → `value`=0, `pwm_on`=0, `state`=0 without waiting for a clk.
  - After release, OFF until a new `light` edge.
